// File: rtl/bit_extender_pkg.sv
// Shared ext_op encodings for the datapath (decoder, ALU, extenders).
package bit_extender_pkg;

    localparam logic EXT_ZERO = 1'b0;
    localparam logic EXT_SIGN = 1'b1;

endpackage

// File: rtl/bit_extender.sv
// Zero/sign-extends an IN_W-bit field to OUT_W bits, with an optional
// single-cycle output register for retiming.
module bit_extender
    import bit_extender_pkg::*;
#(
    parameter int          IN_W    = 16,
    parameter int          OUT_W   = 32,
    parameter int unsigned OUT_REG = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ext_op,
    input  logic [IN_W-1:0]  din,
    input  logic             in_valid,
    output logic [OUT_W-1:0] dout,
    output logic             out_valid
);

    logic [OUT_W-1:0] ext_c;

    // Extension: illegal widths stop elaboration; equal widths pass straight through.
    generate
        if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
            $error("bit_extender: IN_W (%0d) must be in 1..OUT_W (%0d)", IN_W, OUT_W);
            assign ext_c = '0;
            logic unused_bad;
            assign unused_bad = ^{ext_op, din};
        end else if (IN_W == OUT_W) begin : g_pass
            assign ext_c = din;
            logic unused_ext_op;
            assign unused_ext_op = ext_op;
        end else begin : g_ext
            localparam int FILL_W = OUT_W - IN_W;
            logic fill_bit;
            assign fill_bit = (ext_op == EXT_SIGN) & din[IN_W-1];
            assign ext_c    = {{FILL_W{fill_bit}}, din};
        end
    endgenerate

    // Output stage: registered with async clear, or a plain feed-through.
    generate
        if (OUT_REG != 0) begin : g_reg
            logic [OUT_W-1:0] dout_q;
            logic             valid_q;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    dout_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    dout_q  <= ext_c;
                    valid_q <= in_valid;
                end
            end

            assign dout      = dout_q;
            assign out_valid = valid_q;
        end else begin : g_comb
            assign dout      = ext_c;
            assign out_valid = in_valid;
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst_n;
        end
    endgenerate

endmodule

// File: tb/tb_bit_extender.sv
// Scoreboard bench for bit_extender across combinational, 1-bit, registered
// and pass-through configurations.
module tb_bit_extender;

    logic clk;
    logic rst_n;

    // 16 -> 32, combinational
    logic        op16, v16, ov16;
    logic [15:0] din16;
    logic [31:0] d16;
    // 1 -> 32, combinational
    logic        op1, v1, ov1;
    logic [0:0]  din1;
    logic [31:0] d1;
    // 16 -> 32, registered
    logic        opr, vr, ovr;
    logic [15:0] dinr;
    logic [31:0] dr;
    // 8 -> 8, pass-through
    logic        op8, v8, ov8;
    logic [7:0]  din8;
    logic [7:0]  d8;

    logic [31:0] q16[$];
    logic [31:0] q1[$];
    logic [31:0] qr[$];
    logic [31:0] q8[$];

    int checks;
    int failures;

    bit_extender #(16, 32, 0) u_ext16 (
        .clk(clk), .rst_n(rst_n), .ext_op(op16), .din(din16),
        .in_valid(v16), .dout(d16), .out_valid(ov16)
    );
    bit_extender #(1, 32, 0) u_ext1 (
        .clk(clk), .rst_n(rst_n), .ext_op(op1), .din(din1),
        .in_valid(v1), .dout(d1), .out_valid(ov1)
    );
    bit_extender #(16, 32, 1) u_extr (
        .clk(clk), .rst_n(rst_n), .ext_op(opr), .din(dinr),
        .in_valid(vr), .dout(dr), .out_valid(ovr)
    );
    bit_extender #(8, 8, 0) u_ext8 (
        .clk(clk), .rst_n(rst_n), .ext_op(op8), .din(din8),
        .in_valid(v8), .dout(d8), .out_valid(ov8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expected word per valid output, sampled mid-cycle.
    always @(negedge clk) begin
        if (ov16) begin
            if (q16.size() == 0) check("ext16_unexpected", d16, 32'hxxxx_xxxx);
            else check("ext16", d16, q16.pop_front());
        end
        if (ov1) begin
            if (q1.size() == 0) check("ext1_unexpected", d1, 32'hxxxx_xxxx);
            else check("ext1", d1, q1.pop_front());
        end
        if (ovr) begin
            if (qr.size() == 0) check("extreg_unexpected", dr, 32'hxxxx_xxxx);
            else check("extreg", dr, qr.pop_front());
        end
        if (ov8) begin
            if (q8.size() == 0) check("ext8_unexpected", {24'h0, d8}, 32'hxxxx_xxxx);
            else check("ext8", {24'h0, d8}, q8.pop_front());
        end
    end

    task automatic drive16(input logic op, input logic [15:0] d, input logic [31:0] exp);
        @(posedge clk); #1;
        op16 = op; din16 = d; v16 = 1'b1;
        q16.push_back(exp);
    endtask

    task automatic drive1(input logic op, input logic d, input logic [31:0] exp);
        @(posedge clk); #1;
        op1 = op; din1 = d; v1 = 1'b1;
        q1.push_back(exp);
    endtask

    task automatic drive_reg(input logic op, input logic [15:0] d, input logic [31:0] exp);
        @(posedge clk); #1;
        opr = op; dinr = d; vr = 1'b1;
        qr.push_back(exp);
    endtask

    task automatic drive8(input logic op, input logic [7:0] d, input logic [31:0] exp);
        @(posedge clk); #1;
        op8 = op; din8 = d; v8 = 1'b1;
        q8.push_back(exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] r16;
        logic [7:0]  r8;
        logic        rop;

        checks = 0; failures = 0;
        rst_n = 1'b0;
        op16 = 0; din16 = '0; v16 = 0;
        op1 = 0; din1 = '0; v1 = 0;
        opr = 0; dinr = '0; vr = 0;
        op8 = 0; din8 = '0; v8 = 0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_dout", dr, 32'h0);
        check("reset_valid", {31'h0, ovr}, 32'h0);
        rst_n = 1'b1;

        // 16 -> 32 directed vectors and a signed/unsigned reference sweep
        drive16(1'b1, 16'h8001, 32'hFFFF_8001);
        drive16(1'b0, 16'h8001, 32'h0000_8001);
        drive16(1'b1, 16'h7FFF, 32'h0000_7FFF);
        drive16(1'b0, 16'hFFFF, 32'h0000_FFFF);
        for (int i = 0; i < 8; i++) begin
            r16 = 16'($urandom());
            rop = 1'($urandom());
            drive16(rop, r16, rop ? 32'($signed(r16)) : 32'($unsigned(r16)));
        end
        @(posedge clk); #1; v16 = 1'b0;

        // 1 -> 32 all-ones / one / zero words
        drive1(1'b1, 1'b1, 32'hFFFF_FFFF);
        drive1(1'b0, 1'b1, 32'h0000_0001);
        drive1(1'b1, 1'b0, 32'h0000_0000);
        drive1(1'b0, 1'b0, 32'h0000_0000);
        @(posedge clk); #1; v1 = 1'b0;

        // Registered: new value only after the capturing edge
        drive_reg(1'b0, 16'h1234, 32'h0000_1234);
        drive_reg(1'b1, 16'hFFFE, 32'hFFFF_FFFE);
        check("reg_prior_value", dr, 32'h0000_1234);
        @(posedge clk); #1; vr = 1'b0;
        check("reg_after_edge", dr, 32'hFFFF_FFFE);
        @(posedge clk); #1;
        check("reg_valid_drop", {31'h0, ovr}, 32'h0);

        // Async reset mid-stream discards the in-flight value
        drive_reg(1'b1, 16'h8000, 32'hFFFF_8000);
        @(posedge clk); #3;
        rst_n = 1'b0;
        qr.delete();
        #1;
        check("async_rst_dout", dr, 32'h0);
        check("async_rst_valid", {31'h0, ovr}, 32'h0);
        for (int i = 0; i < 3; i++) begin
            opr = ~opr; dinr = 16'hF00F ^ 16'(i); vr = 1'b1;
            @(posedge clk); #1;
            check("rst_hold_dout", dr, 32'h0);
            check("rst_hold_valid", {31'h0, ovr}, 32'h0);
        end
        #2;
        rst_n = 1'b1;
        opr = 1'b0; dinr = 16'hABCD; vr = 1'b1;
        qr.push_back(32'h0000_ABCD);
        #1;
        check("release_before_edge", dr, 32'h0);
        @(posedge clk); #1; vr = 1'b0;

        // 8 -> 8 pass-through
        drive8(1'b0, 8'hA5, 32'h0000_00A5);
        drive8(1'b1, 8'hA5, 32'h0000_00A5);
        for (int i = 0; i < 8; i++) begin
            r8 = 8'($urandom());
            rop = 1'($urandom());
            drive8(rop, r8, {24'h0, rop ? 8'($signed(r8)) : 8'($unsigned(r8))});
        end
        @(posedge clk); #1; v8 = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("drain_q16", 32'(q16.size()), 32'h0);
        check("drain_q1", 32'(q1.size()), 32'h0);
        check("drain_qr", 32'(qr.size()), 32'h0);
        check("drain_q8", 32'(q8.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
